// File: rtl/uart_boot_loader_if.sv
// Instruction-memory write port driven by the UART boot loader.
// The loader is the master; the memory grants one request per cycle.
interface uart_boot_loader_if #(
    parameter int ADDR_W = 12
);
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_gnt_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_gnt_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_gnt_i
    );
endinterface

// File: rtl/uart_boot_loader.sv
// Packs UART boot bytes (LSB first) into words, writes them to IMEM
// and holds the core in reset until the terminator word arrives.
module uart_boot_loader #(
    parameter int          ADDR_W         = 12,
    parameter logic [31:0] TERMINATOR     = 32'h00000FFF,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    uart_boot_loader_if.master mem,
    output logic              core_rst_no,
    output logic              boot_done_o,
    output logic              boot_err_o,
    output logic [ADDR_W:0]   word_count_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_BOOT,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_e;

    state_e state_q, state_d;

    logic [1:0]        byte_idx_q;
    logic [23:0]       asm_q;
    logic [TW-1:0]     tmo_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   cnt_q;
    logic              done_q;
    logic              err_q;

    logic              gnt_hit;
    logic              busy;
    logic              in_boot;
    logic              word_done;
    logic              issue;
    logic [31:0]       word;
    logic [ADDR_W:0]   cnt_eff;

    assign gnt_hit   = req_q & mem.mem_gnt_i;
    assign busy      = req_q & ~mem.mem_gnt_i;
    assign cnt_eff   = cnt_q + {{ADDR_W{1'b0}}, gnt_hit};
    assign in_boot   = (state_q == S_BOOT);
    assign word      = {rx_data_i, asm_q};
    assign word_done = in_boot & rx_valid_i & (byte_idx_q == 2'd3);

    // A grant in the completing cycle frees the slot and advances the address.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            S_BOOT: begin
                if (word_done) begin
                    if (word == TERMINATOR)
                        state_d = busy ? S_DRAIN : S_DONE;
                    else if (busy)
                        state_d = S_ERR;
                    else if (cnt_eff == CAP)
                        state_d = S_ERR;
                    else
                        issue = 1'b1;
                end
            end
            S_DRAIN: begin
                if (gnt_hit)
                    state_d = S_DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_BOOT;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == S_DONE);
            err_q   <= (state_d == S_ERR);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_idx_q <= 2'd0;
            asm_q      <= 24'd0;
            tmo_q      <= '0;
        end else if (in_boot) begin
            if (rx_valid_i) begin
                tmo_q      <= '0;
                byte_idx_q <= byte_idx_q + 2'd1;
                if (byte_idx_q != 2'd3)
                    asm_q[{byte_idx_q, 3'b000} +: 8] <= rx_data_i;
            end else if (byte_idx_q != 2'd0) begin
                if (tmo_q == TMO_LAST) begin
                    byte_idx_q <= 2'd0;
                    tmo_q      <= '0;
                    asm_q      <= 24'd0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_eff;
            if (issue) begin
                req_q   <= 1'b1;
                addr_q  <= cnt_eff[ADDR_W-1:0];
                wdata_q <= word;
            end else if (gnt_hit) begin
                req_q <= 1'b0;
            end
        end
    end

    assign mem.mem_req_o   = req_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_wdata_o = wdata_q;
    assign core_rst_no     = done_q;
    assign boot_done_o     = done_q;
    assign boot_err_o      = err_q;
    assign word_count_o    = cnt_q;

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Consumes the byte stream produced by the SoC's UART receiver during boot and packs it into 32-bit words, least-significant byte first. It writes each word to instruction memory at consecutive word addresses starting at 0. It holds the core in reset until the terminator word `0x00000FFF` arrives and the last write has been granted, then releases it. It sits between the UART RX byte output and the instruction-memory write port, in front of the core reset.

## Interface
- `ADDR_W`, 12: instruction-memory word-address width; capacity is 2^ADDR_W words.
- `TERMINATOR`, 32'h00000FFF: end-of-program word; it is never written to memory.
- `TIMEOUT_CYCLES`, 4096: idle cycles after which a partial word is discarded; ≥ 2.
- `clk_i`  in  1  single clock; all logic on its rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `rx_valid_i`  in  1  one-cycle strobe, one received byte.
- `rx_data_i`  in  8  received byte, valid with `rx_valid_i`.
- `mem_req_o`  out  1  write request.
- `mem_addr_o`  out  ADDR_W  word address of the write.
- `mem_wdata_o`  out  32  write data.
- `mem_gnt_i`  in  1  memory accepts the request in this cycle.
- `core_rst_no`  out  1  active-low core reset; 0 while booting.
- `boot_done_o`  out  1  terminator received and all writes complete; sticky.
- `boot_err_o`  out  1  overflow or overrun; sticky.
- `word_count_o`  out  ADDR_W+1  number of granted writes.

## Operation
- States:
  - BOOT: reset state.
  - DRAIN: terminator seen, write still pending.
  - DONE.
  - ERROR.
- Assembly:
  - 2-bit `byte_idx` and 24-bit `asm_q`.
  - When `rx_valid_i` is high in BOOT and `byte_idx` < 3: store the byte at lane `byte_idx` and increment `byte_idx`.
  - When `byte_idx` == 3: form `word = {rx_data_i, asm_q}` and clear `byte_idx` to 0.
- Word completion in BOOT, evaluated in this priority order:
  1. `word == TERMINATOR`: go to DRAIN if a write is pending, otherwise go to DONE. No write is issued.
  2. A write is pending (`mem_req_o` = 1 and no grant in this cycle): go to ERROR (overrun).
  3. `word_count_o == 2^ADDR_W`: go to ERROR (overflow).
  4. Otherwise: `mem_wdata_o <= word`, `mem_addr_o <= word_count_o[ADDR_W-1:0]`, `mem_req_o <= 1`.
- A grant in the same cycle as word completion frees the slot, so the new request is legal.
- Write handshake:
  - `mem_req_o` stays high until it is sampled together with `mem_gnt_i`.
  - `mem_addr_o` and `mem_wdata_o` stay stable while `mem_req_o` is high.
  - On a grant, `word_count_o` increments by 1 and `mem_req_o` drops on the next edge.
- Timeout:
  - A counter clears on every `rx_valid_i` and counts while `byte_idx` ≠ 0 in BOOT.
  - When it reaches `TIMEOUT_CYCLES`: clear `byte_idx` and the counter, discard `asm_q`. No flag is raised.
- DRAIN: bytes are ignored; on the grant go to DONE.
- DONE:
  - `core_rst_no` = 1 and `boot_done_o` = 1.
  - All bytes are ignored.
  - Exit only by reset.
- ERROR:
  - `boot_err_o` = 1 and `core_rst_no` = 0.
  - All bytes are ignored.
  - A write already pending still completes and is counted.
  - Exit only by reset.
- Reset, including mid-word or mid-write:
  - Outputs: `mem_req_o`, `mem_addr_o`, `mem_wdata_o`, `boot_done_o`, `boot_err_o`, `word_count_o` all 0; `core_rst_no` = 0.
  - Internal: `byte_idx` = 0, timeout counter = 0, state = BOOT.
  - A pending request is dropped immediately.

## Timing
- All outputs are registered.
- The 4th byte is strobed at edge N; `mem_req_o`, `mem_addr_o` and `mem_wdata_o` are valid after N+1.
- With `mem_gnt_i` tied high, `mem_req_o` is high for exactly 1 cycle and `word_count_o` updates after N+2.
- Terminator with no write pending: `boot_done_o` and `core_rst_no` rise after N+1.
- Terminator in DRAIN: `boot_done_o` and `core_rst_no` rise on the edge after the grant edge.
- `boot_err_o` rises after the edge that completed the offending word.
- Minimum byte spacing supported: 1 cycle, i.e. back-to-back `rx_valid_i`.

## Test plan
1. Bytes 13,05,00,00, FF,0F,00,00 with `mem_gnt_i` = 1: one write, addr 0, data 0x00000513. Then `word_count_o` = 1, `boot_done_o` = 1, `core_rst_no` = 1.
2. Grant delayed 20 cycles, terminator bytes sent during the wait: `mem_req_o`, addr and data stay stable. `boot_done_o` stays 0 until the cycle after the grant.
3. Bytes AA,BB, then `TIMEOUT_CYCLES` + 5 idle cycles, then 11,22,33,44: a single write of 0x44332211 to addr 0.
4. `ADDR_W` = 2, gnt = 1: four words go to addrs 0–3. A fifth non-terminator word gives `boot_err_o` = 1, no fifth request, `core_rst_no` = 0, `word_count_o` = 4.
5. `mem_gnt_i` = 0, two complete words back-to-back: `boot_err_o` = 1. The first request completes when gnt is later raised; `word_count_o` = 1.
6. `rst_ni` pulsed low while `mem_req_o` = 1 and `byte_idx` = 2: all outputs return to reset values at once. The next four bytes form a fresh word written to addr 0.
